// File: rtl/ftoi.sv
// Float32 to signed int32 conversion, round to nearest, ties away.
// One-cycle registered result with saturation and overflow flag.
module ftoi (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] x1,
  output logic        out_valid,
  output logic [31:0] y,
  output logic        ovf
);

  logic        s;
  logic [7:0]  e;
  logic [22:0] m;
  logic [31:0] sig;
  logic [7:0]  rsh;
  logic [7:0]  lsh;
  logic [31:0] shr;
  logic [31:0] rbits;
  logic [31:0] mag;
  logic [31:0] res;
  logic        res_ovf;

  // Decode, shift, round and saturate the operand.
  always_comb begin
    s       = x1[31];
    e       = x1[30:23];
    m       = x1[22:0];
    sig     = {8'd0, 1'b1, m};
    rsh     = 8'd150 - e;
    lsh     = e - 8'd150;
    shr     = sig >> rsh[4:0];
    rbits   = sig >> (rsh[4:0] - 5'd1);
    mag     = 32'd0;
    res     = 32'd0;
    res_ovf = 1'b0;
    unique case (1'b1)
      (e == 8'd255): begin
        res_ovf = 1'b1;
        if (m != 23'd0)
          res = 32'h7FFF_FFFF;
        else
          res = s ? 32'h8000_0000
                  : 32'h7FFF_FFFF;
      end
      (e >= 8'd158 && e != 8'd255): begin
        if (s) begin
          res     = 32'h8000_0000;
          res_ovf = (m != 23'd0);
        end else begin
          res     = 32'h7FFF_FFFF;
          res_ovf = 1'b1;
        end
      end
      (e >= 8'd150 && e < 8'd158): begin
        mag = sig << lsh[2:0];
        res = s ? (32'd0 - mag) : mag;
      end
      (e >= 8'd126 && e < 8'd150): begin
        mag = shr + {31'd0, rbits[0]};
        res = s ? (32'd0 - mag) : mag;
      end
      (e < 8'd126): begin
        res = 32'd0;
      end
    endcase
  end

  // Register result; hold y/ovf when no operand is offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= 32'd0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y   <= res;
        ovf <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_ftoi.sv
// Directed-vector bench for ftoi.
// Table of conversions plus pipeline and reset sequences.
module tb_ftoi;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] x1;
  logic        out_valid;
  logic [31:0] y;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] ey;
    logic        eovf;
  } vec_t;

  vec_t vecs[$];

  ftoi dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .x1(x1),
    .out_valid(out_valid),
    .y(y),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] ey,
                     input logic eovf,
                     input logic ev);
    checks++;
    if (y !== ey || ovf !== eovf || out_valid !== ev) begin
      errors++;
      $display("FAIL %s: got y=%h ovf=%b v=%b, want y=%h ovf=%b v=%b",
               name, y, ovf, out_valid, ey, eovf, ev);
    end
  endtask

  initial begin
    vecs.push_back('{"r1.5",    32'h3FC00000, 32'd2,        1'b0});
    vecs.push_back('{"r2.5",    32'h40200000, 32'd3,        1'b0});
    vecs.push_back('{"rm2.5",   32'hC0200000, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{"h_below", 32'h3EFFFFFF, 32'd0,        1'b0});
    vecs.push_back('{"h_0.5",   32'h3F000000, 32'd1,        1'b0});
    vecs.push_back('{"h_m0.5",  32'hBF000000, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"h_0.99",  32'h3F7FFFFF, 32'd1,        1'b0});
    vecs.push_back('{"z_p0",    32'h00000000, 32'd0,        1'b0});
    vecs.push_back('{"z_m0",    32'h80000000, 32'd0,        1'b0});
    vecs.push_back('{"z_den",   32'h00400000, 32'd0,        1'b0});
    vecs.push_back('{"z_mden",  32'h807FFFFF, 32'd0,        1'b0});
    vecs.push_back('{"big_p",   32'h4EFFFFFF, 32'd2147483520, 1'b0});
    vecs.push_back('{"big_m",   32'hCEFFFFFF, 32'h80000080, 1'b0});
    vecs.push_back('{"exact",   32'h4B000001, 32'd8388609,  1'b0});
    vecs.push_back('{"near2",   32'h3FFFFFFF, 32'd2,        1'b0});
    vecs.push_back('{"pi",      32'h40490FDB, 32'd3,        1'b0});
    vecs.push_back('{"s_2p31",  32'h4F000000, 32'h7FFFFFFF, 1'b1});
    vecs.push_back('{"s_m2p31", 32'hCF000000, 32'h80000000, 1'b0});
    vecs.push_back('{"s_mbig",  32'hCF000001, 32'h80000000, 1'b1});
    vecs.push_back('{"s_pinf",  32'h7F800000, 32'h7FFFFFFF, 1'b1});
    vecs.push_back('{"s_nan",   32'h7FC00000, 32'h7FFFFFFF, 1'b1});
    vecs.push_back('{"s_minf",  32'hFF800000, 32'h80000000, 1'b1});
    vecs.push_back('{"s_mnan",  32'hFFC00000, 32'h7FFFFFFF, 1'b1});

    rst      = 1'b1;
    in_valid = 1'b0;
    x1       = 32'd0;
    #12;
    chk("reset", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      x1       = vecs[i].x;
      @(posedge clk);
      #1;
      chk(vecs[i].name, vecs[i].ey, vecs[i].eovf, 1'b1);
    end

    @(negedge clk);
    in_valid = 1'b1;
    x1       = 32'h3F800000;
    @(posedge clk);
    #1;
    chk("stream1", 32'd1, 1'b0, 1'b1);
    @(negedge clk);
    x1 = 32'h40000000;
    @(posedge clk);
    #1;
    chk("stream2", 32'd2, 1'b0, 1'b1);
    @(negedge clk);
    x1 = 32'h40400000;
    @(posedge clk);
    #1;
    chk("stream3", 32'd3, 1'b0, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    x1       = 32'h4F000000;
    @(posedge clk);
    #1;
    chk("hold1", 32'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("hold2", 32'd3, 1'b0, 1'b0);

    @(negedge clk);
    in_valid = 1'b1;
    x1       = 32'h4F000000;
    @(posedge clk);
    #1;
    chk("pre_rst", 32'h7FFFFFFF, 1'b1, 1'b1);
    @(negedge clk);
    x1 = 32'h40200000;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("in_rst", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    x1       = 32'hC0200000;
    @(posedge clk);
    #1;
    chk("post_rst", 32'hFFFFFFFD, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
